// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: round-robin sharing of a single synchronous_fifo write port among
// NUM_REQ valid/ready requesters.
// Build option: FIFO_ARB_BURST_EN lets an owner keep the grant for up to MAX_BURST
// consecutive transfers; without it the grant rotates after every word.
module fifo_write_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MAX_BURST  = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_data_in,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          busy
);

  localparam int unsigned IdW = $clog2(NUM_REQ);

  typedef enum logic {StIdle, StGrant} state_e;

  state_e         state_q, state_d;
  logic [IdW-1:0] grant_q, grant_d;
  logic [IdW-1:0] last_q, last_d;
  logic [IdW-1:0] winner;
  logic           any_valid;
  logic           xfer;
  logic           burst_done;
  logic           new_grant;

  // Round-robin search from last_q+1; the previous winner is naturally the last candidate.
  always_comb begin
    winner    = '0;
    any_valid = 1'b0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      logic [IdW-1:0] cand;
      cand = IdW'((32'(last_q) + k) % NUM_REQ);
      if (!any_valid && req_valid[cand]) begin
        any_valid = 1'b1;
        winner    = cand;
      end
    end
  end

  // Outputs decode straight from the registered owner; a stalled FIFO blocks the handshake.
  always_comb begin
    xfer               = (state_q == StGrant) && req_valid[grant_q] && !fifo_full;
    req_ready          = '0;
    req_ready[grant_q] = xfer;
    fifo_wr_en         = xfer;
    fifo_data_in       = '0;
    if (state_q == StGrant) begin
      fifo_data_in = req_data[32'(grant_q) * DATA_WIDTH +: DATA_WIDTH];
    end
    busy     = (state_q == StGrant);
    grant_id = grant_q;
  end

`ifdef FIFO_ARB_BURST_EN
  localparam int unsigned CntW = $clog2(MAX_BURST) + 1;

  logic [CntW-1:0] burst_cnt_q, burst_cnt_d;

  assign burst_done = xfer && ((burst_cnt_q + CntW'(1)) == CntW'(MAX_BURST));

  // Burst counter restarts on every grant (including a self re-grant) and freezes on stall.
  always_comb begin
    burst_cnt_d = burst_cnt_q;
    if (new_grant) begin
      burst_cnt_d = '0;
    end else if (xfer) begin
      burst_cnt_d = burst_cnt_q + CntW'(1);
    end
  end

  // Burst counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      burst_cnt_q <= '0;
    end else begin
      burst_cnt_q <= burst_cnt_d;
    end
  end
`else
  // Burst limit of one: every transfer ends the grant.
  assign burst_done = xfer;

  logic unused_max_burst;
  assign unused_max_burst = (MAX_BURST != 0);
`endif

  // Grant, release and same-edge handover; a dropped owner valid counts as a release.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    new_grant = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (any_valid) begin
          new_grant = 1'b1;
        end
      end
      StGrant: begin
        if (!req_valid[grant_q] || burst_done) begin
          if (any_valid) begin
            new_grant = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    if (new_grant) begin
      state_d = StGrant;
      grant_d = winner;
      last_d  = winner;
    end
  end

  // State registers; last_q resets to NUM_REQ-1 so requester 0 wins first.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      grant_q <= '0;
      last_q  <= IdW'(NUM_REQ - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

endmodule
